video_cmd_sink: RTL and testbench
=================================

VIDEO_CMD_SINK -- requirements
Module: video_cmd_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, >=2).
REQ-002 Parameter COLS, default 80, characters per row.
REQ-003 Parameter ROWS, default 30, character rows; SCREEN = COLS*ROWS = 2400.
REQ-004 wire_clock  in  1  sole clock; all logic on rising edge.
REQ-005 wire_reset  in  1  asynchronous, active-low reset.
REQ-006 videoflag  in  1  CPU video-write strobe; a command on each 0->1 transition.
REQ-007 bus_vga_pos  in  16  screen position of command.
REQ-008 bus_vga_char  in  16  character/colour word of command.
REQ-009 bus_cram_addr  out  12  character-RAM write address.
REQ-010 bus_cram_data  out  16  character-RAM write data.
REQ-011 wire_cram_we  out  1  write request; transfer when wire_cram_we and wire_cram_ready are both high.
REQ-012 wire_cram_ready  in  1  character RAM accepts the write this cycle.
REQ-013 wire_overflow  out  1  sticky: command lost because FIFO full.
REQ-014 wire_pos_err  out  1  sticky: command dropped, position >= SCREEN.
REQ-015 bus_fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-016 videoflag is registered once; a command is captured in the cycle where videoflag=1 and its registered value=0; holding videoflag high yields one command.
REQ-017 Captured pos/char are those on the buses in the capture cycle.
REQ-018 Capture with pos >= SCREEN: not enqueued, wire_pos_err set.
REQ-019 Capture while FIFO full and no pop that cycle: command discarded, wire_overflow set; capture with simultaneous pop when full is enqueued.
REQ-020 FSM states IDLE, WRITE, CLEAR (CLEAR only under REQ-031).
REQ-021 IDLE: if FIFO non-empty, pop head into output registers and go to WRITE next cycle; minimum latency capture-to-wire_cram_we is 2 cycles.
REQ-022 WRITE: wire_cram_we=1, addr/data held stable until transfer; on transfer, pop next entry and stay in WRITE if FIFO non-empty, else go to IDLE with wire_cram_we=0.
REQ-023 Back-to-back sustained throughput: one write per cycle while wire_cram_ready stays high.
REQ-024 wire_cram_ready low stalls indefinitely; captures continue into FIFO.
REQ-025 Commands reach character RAM in capture order; none duplicated.
REQ-026 bus_fifo_level updates the cycle after each push/pop; simultaneous push and pop leave it unchanged.
REQ-027 Sticky flags clear only on reset.

Reset
REQ-028 While wire_reset=0: FSM IDLE, FIFO empty, bus_fifo_level=0, wire_cram_we=0, bus_cram_addr=0, bus_cram_data=0, wire_overflow=0, wire_pos_err=0, registered videoflag=0.
REQ-029 Reset asserted mid-write aborts the write immediately; queued commands are lost.
REQ-030 After release, videoflag already high produces one command on the first clock edge (registered value was 0).

Configuration
REQ-031 VIDEO_CLEAR_EN defined: a command with bus_vga_char=16'hFFFF (any valid pos) enters CLEAR after preceding commands finish, writing 16'h0020 to addresses 0..SCREEN-1 in ascending order, one per transfer, then resumes FIFO processing; captures during CLEAR are enqueued.
REQ-032 VIDEO_CLEAR_EN undefined: 16'hFFFF is an ordinary character; CLEAR state and its counter absent.

Structure
REQ-033 Shared package holds FSM state encoding, SCREEN constant, clear character 16'h0020 and clear code 16'hFFFF.
REQ-034 FIFO is one sub-module, video_cmd_fifo (32-bit entries {pos[11:0] zero-extended, char}, push/pop/full/empty/level).

Verification
REQ-035 Reset, videoflag pulse pos=5 char=16'h0141, ready=1 -> single write addr=5 data=16'h0141, we high exactly 1 cycle, 2 cycles after capture.
REQ-036 videoflag held high 10 cycles -> exactly one write.
REQ-037 ready=0, 10 distinct commands -> level saturates at 8, wire_overflow=1; ready=1 -> first 8 written in order, last 2 lost.
REQ-038 pos=2400 -> no write, wire_pos_err=1; pos=2399 -> write addr 2399.
REQ-039 VIDEO_CLEAR_EN, char=16'hFFFF then pos=0 char=16'h0058 -> 2400 writes of 16'h0020 to 0..2399, then addr 0 data 16'h0058.
REQ-040 Reset asserted during stalled write with 3 queued -> we=0, level=0 immediately; no writes after release.

Source files
------------

// File: rtl/video_cmd_sink_pkg.sv
// ============================================================================
// Module : video_cmd_sink_pkg
// Brief  : Shared FSM encoding, screen geometry and character constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package video_cmd_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef VIDEO_CLEAR_EN
    ST_CLEAR = 2'd2,
`endif
    ST_WRITE = 2'd1
  } state_e;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 30;
  localparam int unsigned SCREEN   = DEF_COLS * DEF_ROWS;

  localparam logic [15:0] CLEAR_CHAR = 16'h0020;
  localparam logic [15:0] CLEAR_CODE = 16'hFFFF;

  // FIFO entry layout: {pos[11:0] zero-extended to 16 bits, char}
  function automatic logic [31:0] pack_cmd(input logic [15:0] pos, input logic [15:0] chr);
    return {4'h0, pos[11:0], chr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_cmd_fifo.sv
// ============================================================================
// Module : video_cmd_fifo
// Brief  : Power-of-two command FIFO; push while full is accepted only with a
//          simultaneous pop. Head entry is read combinationally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module video_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/video_cmd_sink.sv
// ============================================================================
// Module : video_cmd_sink
// Brief  : Captures CPU video-write strobes into a FIFO and replays them as
//          character-RAM writes. Optional screen clear via VIDEO_CLEAR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module video_cmd_sink
  import video_cmd_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COLS       = 80,
  parameter int ROWS       = 30
) (
  input  logic        wire_clock,
  input  logic        wire_reset,
  input  logic        videoflag,
  input  logic [15:0] bus_vga_pos,
  input  logic [15:0] bus_vga_char,
  output logic [11:0] bus_cram_addr,
  output logic [15:0] bus_cram_data,
  output logic        wire_cram_we,
  input  logic        wire_cram_ready,
  output logic        wire_overflow,
  output logic        wire_pos_err,
  output logic [3:0]  bus_fifo_level
);

  localparam int          LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int          SCREEN_CELLS = COLS * ROWS;
  localparam logic [15:0] SCREEN_LIM  = 16'(SCREEN_CELLS);
`ifdef VIDEO_CLEAR_EN
  localparam logic [11:0] SCREEN_LAST = 12'(SCREEN_CELLS - 1);
`endif

  state_e         state_q, state_d;
  logic           vflag_q;
  logic [11:0]    addr_q, addr_d;
  logic [15:0]    data_q, data_d;
  logic           ovf_q, perr_q;

  logic           capture, pos_ok, launch;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]    fifo_rdata;
  logic [LW-1:0]  fifo_level;
  logic [11:0]    head_pos;
  logic [15:0]    head_char;
  logic           unused_hi;

  assign capture   = videoflag && !vflag_q;
  assign pos_ok    = (bus_vga_pos < SCREEN_LIM);
  assign fifo_push = capture && pos_ok;
  assign head_pos  = fifo_rdata[27:16];
  assign head_char = fifo_rdata[15:0];
  assign unused_hi = &{1'b0, fifo_rdata[31:28]};

  video_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (wire_clock),
    .rst_ni  (wire_reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (pack_cmd(bus_vga_pos, bus_vga_char)),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;

    unique case (state_q)
      ST_IDLE: launch = !fifo_empty;
      ST_WRITE: begin
        if (wire_cram_ready) begin
          launch = !fifo_empty;
          if (fifo_empty) state_d = ST_IDLE;
        end
      end
`ifdef VIDEO_CLEAR_EN
      // addr_q doubles as the clear counter
      ST_CLEAR: begin
        if (wire_cram_ready) begin
          if (addr_q != SCREEN_LAST) begin
            addr_d = addr_q + 12'd1;
          end else begin
            launch = !fifo_empty;
            if (fifo_empty) state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      fifo_pop = 1'b1;
`ifdef VIDEO_CLEAR_EN
      if (head_char == CLEAR_CODE) begin
        state_d = ST_CLEAR;
        addr_d  = '0;
        data_d  = CLEAR_CHAR;
      end else begin
        state_d = ST_WRITE;
        addr_d  = head_pos;
        data_d  = head_char;
      end
`else
      state_d = ST_WRITE;
      addr_d  = head_pos;
      data_d  = head_char;
`endif
    end
  end

  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      state_q <= ST_IDLE;
      vflag_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vflag_q <= videoflag;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (capture && !pos_ok)                          perr_q <= 1'b1;
      if (capture && pos_ok && fifo_full && !fifo_pop) ovf_q  <= 1'b1;
    end
  end

  assign wire_cram_we   = (state_q != ST_IDLE);
  assign bus_cram_addr  = addr_q;
  assign bus_cram_data  = data_q;
  assign wire_overflow  = ovf_q;
  assign wire_pos_err   = perr_q;
  assign bus_fifo_level = 4'(fifo_level);

endmodule

`default_nettype wire

// File: tb/tb_video_cmd_sink.sv
// ============================================================================
// Module : tb_video_cmd_sink
// Brief  : Queue-based reference model checked every cycle, plus directed
//          literal checks and randomized traffic. Clear tests need VIDEO_CLEAR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_video_cmd_sink;

  localparam int DEPTH = 8;
  localparam int SCR   = 2400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vf = 1'b0;
  logic [15:0] pos = '0;
  logic [15:0] chr = '0;
  logic        ready = 1'b0;
  logic [11:0] addr;
  logic [15:0] data;
  logic        we, ovf, perr;
  logic [3:0]  lvl;

  int errors = 0;
  int checks = 0;

  video_cmd_sink #(.FIFO_DEPTH(DEPTH), .COLS(80), .ROWS(30)) dut (
    .wire_clock      (clk),
    .wire_reset      (rst_n),
    .videoflag       (vf),
    .bus_vga_pos     (pos),
    .bus_vga_char    (chr),
    .bus_cram_addr   (addr),
    .bus_cram_data   (data),
    .wire_cram_we    (we),
    .wire_cram_ready (ready),
    .wire_overflow   (ovf),
    .wire_pos_err    (perr),
    .bus_fifo_level  (lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands, the write being presented, sticky flags
  bit          m_prev, m_active, m_clearing, m_ovf, m_perr;
  logic [11:0] m_addr;
  logic [15:0] m_data;
  logic [27:0] m_q[$];
  logic [11:0] log_addr[$];
  logic [15:0] log_data[$];

  task automatic m_launch();
    logic [27:0] e;
    e = m_q.pop_front();
    m_active = 1'b1;
    m_clearing = 1'b0;
    m_addr = e[27:16];
    m_data = e[15:0];
`ifdef VIDEO_CLEAR_EN
    if (e[15:0] == 16'hFFFF) begin
      m_clearing = 1'b1;
      m_addr = 12'd0;
      m_data = 16'h0020;
    end
`endif
  endtask

  task automatic m_step();
    bit cap;
    cap = vf && !m_prev;
    if (!m_active) begin
      if (m_q.size() > 0) m_launch();
    end else if (ready) begin
      if (m_clearing && m_addr != 12'(SCR - 1)) m_addr = m_addr + 12'd1;
      else if (m_q.size() > 0) m_launch();
      else begin
        m_active = 1'b0;
        m_clearing = 1'b0;
      end
    end
    if (cap) begin
      if (pos >= 16'(SCR)) m_perr = 1'b1;
      else if (m_q.size() < DEPTH) m_q.push_back({pos[11:0], chr});
      else m_ovf = 1'b1;
    end
    m_prev = vf;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_we", 32'(we), 32'(0));
      check("rst_level", 32'(lvl), 32'(0));
      check("rst_addr", 32'(addr), 32'(0));
      check("rst_data", 32'(data), 32'(0));
      check("rst_flags", 32'({ovf, perr}), 32'(0));
      m_prev = 0; m_active = 0; m_clearing = 0; m_ovf = 0; m_perr = 0;
      m_q.delete();
    end else begin
      check("we", 32'(we), 32'(m_active));
      if (m_active) begin
        check("addr", 32'(addr), 32'(m_addr));
        check("data", 32'(data), 32'(m_data));
      end
      check("level", 32'(lvl), 32'(m_q.size()));
      check("overflow", 32'(ovf), 32'(m_ovf));
      check("pos_err", 32'(perr), 32'(m_perr));
      if (we && ready) begin
        log_addr.push_back(addr);
        log_data.push_back(data);
      end
      m_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] p, input logic [15:0] c);
    vf = 1'b1; pos = p; chr = c;
    tick();
    vf = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n0;
    int bad;
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_we", 32'(we), 32'(0));
    check("reset_level", 32'(lvl), 32'(0));
    check("reset_ovf", 32'(ovf), 32'(0));
    check("reset_perr", 32'(perr), 32'(0));
    tick();
    rst_n = 1'b1; ready = 1'b1;
    repeat (2) tick();

    // single command: we rises two cycles after the capture edge, for one cycle
    vf = 1'b1; pos = 16'd5; chr = 16'h0141;
    @(negedge clk); check("t35_we_pre", 32'(we), 32'(0));
    tick(); vf = 1'b0;
    @(negedge clk); check("t35_we_c1", 32'(we), 32'(0));
    @(negedge clk); check("t35_we_c2", 32'(we), 32'(1));
    check("t35_addr", 32'(addr), 32'd5);
    check("t35_data", 32'(data), 32'h0141);
    @(negedge clk); check("t35_we_c3", 32'(we), 32'(0));
    tick();

    n0 = log_addr.size();
    vf = 1'b1; pos = 16'd7; chr = 16'h0042;
    repeat (10) tick();
    vf = 1'b0;
    repeat (6) tick();
    check("t36_writes", 32'(log_addr.size() - n0), 32'd1);

    // A blocker occupies the output register so all 10 commands contend for FIFO space
    ready = 1'b0;
    n0 = log_addr.size();
    pulse(16'd100, 16'h0AAA);
    for (int i = 0; i < 10; i++) pulse(16'(10 + i), 16'(16'h0100 + i));
    @(negedge clk);
    check("t37_level", 32'(lvl), 32'd8);
    check("t37_ovf", 32'(ovf), 32'd1);
    tick(); ready = 1'b1;
    repeat (15) tick();
    check("t37_writes", 32'(log_addr.size() - n0), 32'd9);
    if (log_addr.size() >= n0 + 9) begin
      check("t37_blocker", 32'(log_addr[n0]), 32'd100);
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (log_addr[n0+1+i] != 12'(10 + i) || log_data[n0+1+i] != 16'(16'h0100 + i)) bad++;
      check("t37_order", 32'(bad), 32'd0);
    end
    check("t37_ovf_sticky", 32'(ovf), 32'd1);

    n0 = log_addr.size();
    pulse(16'd2400, 16'h1234);
    repeat (3) tick();
    check("t38_perr", 32'(perr), 32'd1);
    check("t38_nowrite", 32'(log_addr.size() - n0), 32'd0);
    pulse(16'd2399, 16'h5678);
    repeat (4) tick();
    check("t38_writes", 32'(log_addr.size() - n0), 32'd1);
    check("t38_addr", 32'(log_addr[$]), 32'd2399);
    check("t38_data", 32'(log_data[$]), 32'h5678);

    ready = 1'b0;
    pulse(16'd200, 16'h0001);
    pulse(16'd201, 16'h0002);
    pulse(16'd202, 16'h0003);
    pulse(16'd203, 16'h0004);
    @(negedge clk);
    check("t40_level_pre", 32'(lvl), 32'd3);
    check("t40_we_pre", 32'(we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t40_we_rst", 32'(we), 32'd0);
    check("t40_level_rst", 32'(lvl), 32'd0);
    check("t40_ovf_rst", 32'(ovf), 32'd0);
    repeat (2) tick();
    n0 = log_addr.size();
    rst_n = 1'b1; ready = 1'b1;
    repeat (10) tick();
    check("t40_nowrite", 32'(log_addr.size() - n0), 32'd0);

    // videoflag already high at reset release yields exactly one command
    rst_n = 1'b0;
    vf = 1'b1; pos = 16'd9; chr = 16'h0033;
    repeat (2) tick();
    n0 = log_addr.size();
    rst_n = 1'b1;
    repeat (8) tick();
    vf = 1'b0;
    tick();
    check("t30_writes", 32'(log_addr.size() - n0), 32'd1);
    check("t30_addr", 32'(log_addr[$]), 32'd9);

    for (int i = 0; i < 3000; i++) begin
      vf = 1'($urandom_range(0, 1));
      pos = ($urandom_range(0, 15) == 0) ? 16'(SCR + $urandom_range(0, 300))
                                         : 16'($urandom_range(0, SCR - 1));
      chr = 16'($urandom);
      if (((i / 250) % 2) == 1) ready = ($urandom_range(0, 3) == 0);
      else                      ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    vf = 1'b0; ready = 1'b1;
    repeat (30) tick();

`ifdef VIDEO_CLEAR_EN
    n0 = log_addr.size();
    pulse(16'd3, 16'hFFFF);
    pulse(16'd0, 16'h0058);
    repeat (2420) tick();
    check("t39_writes", 32'(log_addr.size() - n0), 32'd2401);
    if (log_addr.size() >= n0 + 2401) begin
      bad = 0;
      for (int i = 0; i < SCR; i++)
        if (log_addr[n0+i] != 12'(i) || log_data[n0+i] != 16'h0020) bad++;
      check("t39_clear_seq", 32'(bad), 32'd0);
      check("t39_last_addr", 32'(log_addr[n0+SCR]), 32'd0);
      check("t39_last_data", 32'(log_data[n0+SCR]), 32'h0058);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
